event_encoder_8to3: RTL and testbench

- Inverse of the team's 3-to-8 decoder: an 8-line event/request encoder.
- Captures pulses on eight active-high request lines into a pending register, then emits one 3-bit index per event over a valid/ready handshake.
- The index uses the same bit weighting the decoder consumes: a = LSB, c = MSB.
- Sits between event sources (interrupt-style lines) and a consumer that reads one encoded event at a time.

---
 rtl/event_encoder_8to3.sv | 121 ++++++++++++
 tb/tb_event_encoder_8to3.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/event_encoder_8to3.sv
// 8-line event encoder. Pending events are presented as a 3-bit index ({c,b,a}) over valid/ready.
// Define ROUND_ROBIN_EN for round-robin selection; the default is lowest-index-first.
//   state | meaning
//   IDLE  | nothing presented, out_valid low
//   SEND  | index on a/b/c held until out_ready
module event_encoder_8to3 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [0:7]       req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic [0:7]       pending,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             ovf
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q;
    logic [0:7]       pending_q;
    logic [2:0]       idx_q;
    logic             valid_q;
    logic [CNT_W-1:0] drop_q;
    logic             ovf_q;

    logic [2:0]       sel_idx;
    logic             load;
    logic [0:7]       capture;
    logic [0:7]       clr_mask;
    logic [0:7]       ovf_bits;
    logic [0:7]       pending_d;
    logic [CNT_W-1:0] drop_d;

`ifdef ROUND_ROBIN_EN
    logic [2:0] last_q;
    logic [2:0] cand;

    // Walk from farthest to nearest so the first index after last_q wins.
    always_comb begin
        sel_idx = '0;
        cand    = '0;
        for (int k = 8; k >= 1; k--) begin
            cand = last_q + 3'(k);
            if (pending_q[cand]) sel_idx = cand;
        end
    end
`else
    always_comb begin
        sel_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (pending_q[i]) sel_idx = 3'(i);
        end
    end
`endif

    always_comb begin
        load     = (|pending_q) && ((state_q == IDLE) || out_ready);
        capture  = en ? '0 : req;
        clr_mask = '0;
        clr_mask[sel_idx] = load;
        // A new request on the bit being cleared this edge re-arms it and is not a drop.
        ovf_bits  = capture & pending_q & ~clr_mask;
        pending_d = (pending_q & ~clr_mask) | capture;
        drop_d    = drop_q;
        if ((|ovf_bits) && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            drop_q    <= '0;
            ovf_q     <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_q    <= 3'd7;
`endif
        end else begin
            pending_q <= pending_d;
            ovf_q     <= |ovf_bits;
            drop_q    <= drop_d;
`ifdef ROUND_ROBIN_EN
            if (load) last_q <= sel_idx;
`endif
            case (state_q)
                IDLE: begin
                    if (load) begin
                        idx_q   <= sel_idx;
                        valid_q <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (load) begin
                        idx_q <= sel_idx;
                    end else if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = valid_q;
    assign a         = idx_q[0];
    assign b         = idx_q[1];
    assign c         = idx_q[2];
    assign pending   = pending_q;
    assign drop_cnt  = drop_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Scoreboard bench for event_encoder_8to3: stimulus queues expected indices, a monitor pops on handshake.
module tb_event_encoder_8to3;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [0:7]       req;
    logic             out_valid;
    logic             out_ready;
    logic             a, b, c;
    logic [0:7]       pending;
    logic [CNT_W-1:0] drop_cnt;
    logic             ovf;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    event_encoder_8to3 #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .c(c),
        .pending(pending), .drop_cnt(drop_cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [0:7] bit_of(input int i);
        logic [0:7] m;
        m    = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic int idx();
        return int'({c, b, a});
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%0d required=none at %0t", idx(), $time);
            end else begin
                chk("sb_index", idx(), exp_q.pop_front());
            end
        end
    end

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        tick();
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_idle_valid"}, int'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; req = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid",   int'(out_valid), 0);
        chk("rst_idx",     idx(), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_drop",    int'(drop_cnt), 0);
        chk("rst_ovf",     int'(ovf), 0);

        // single event, 2-cycle latency
        en = 1'b0; out_ready = 1'b1; req = bit_of(5);
        exp_q.push_back(5);
        tick();
        req = '0;
        chk("single_pend", int'(pending), int'(bit_of(5)));
        chk("single_v0",   int'(out_valid), 0);
        tick();
        chk("single_v1",   int'(out_valid), 1);
        chk("single_idx",  idx(), 5);
        chk("single_pclr", int'(pending), 0);
        tick();
        chk("single_v2",   int'(out_valid), 0);

        // burst, back-to-back
        do_reset();
        req = bit_of(1) | bit_of(6);
        exp_q.push_back(1);
        exp_q.push_back(6);
        tick();
        req = '0;
        tick();
        chk("burst_idx0", idx(), 1);
        tick();
        chk("burst_v1",   int'(out_valid), 1);
        chk("burst_idx1", idx(), 6);
        tick();
        chk("burst_end",  int'(out_valid), 0);

        // backpressure
        do_reset();
        out_ready = 1'b0; req = bit_of(0) | bit_of(2);
        exp_q.push_back(0);
        exp_q.push_back(2);
        tick();
        req = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_idx",   idx(), 0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_next", idx(), 2);
        drain("bp");

        // enable gating
        do_reset();
        en = 1'b1; req = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gate_pend",  int'(pending), 0);
            chk("gate_valid", int'(out_valid), 0);
        end

        // overflow: bit 3 waits behind bit 0, then is pulsed again
        en = 1'b0; out_ready = 1'b0; req = bit_of(0) | bit_of(3);
        exp_q.push_back(0);
        exp_q.push_back(3);
        tick();
        req = '0;
        tick();
        chk("ovf_idx0",  idx(), 0);
        chk("ovf_quiet", int'(ovf), 0);
        req = bit_of(3);
        tick();
        req = '0;
        chk("ovf_pulse", int'(ovf), 1);
        chk("ovf_drop",  int'(drop_cnt), 1);
        chk("ovf_pend",  int'(pending), int'(bit_of(3)));
        tick();
        chk("ovf_once",  int'(ovf), 0);
        chk("ovf_drop1", int'(drop_cnt), 1);
        out_ready = 1'b1;
        tick();
        chk("ovf_idx3",  idx(), 3);
        drain("ovf");
        chk("ovf_pend0", int'(pending), 0);

        // reset mid-SEND: index 4 presented, bit 7 pending, both dropped
        out_ready = 1'b0; req = bit_of(4) | bit_of(7);
        tick();
        req = '0;
        tick();
        chk("mid_idx",  idx(), 4);
        chk("mid_pend", int'(pending), int'(bit_of(7)));
        do_reset();
        chk("mid_valid",   int'(out_valid), 0);
        chk("mid_pend0",   int'(pending), 0);
        chk("mid_drop0",   int'(drop_cnt), 0);
        out_ready = 1'b1; req = bit_of(2);
        exp_q.push_back(2);
        tick();
        req = '0;
        chk("mid_lat0",  int'(out_valid), 0);
        tick();
        chk("mid_lat1",  int'(out_valid), 1);
        chk("mid_fresh", idx(), 2);
        drain("mid");

        // held req on bits 0 and 1
        do_reset();
`ifdef ROUND_ROBIN_EN
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
`else
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
`endif
        req = bit_of(0) | bit_of(1);
        for (int i = 0; i < 5; i++) tick();
        req = '0;
        chk("hold_drop", int'(drop_cnt), 4);
        drain("hold");

        // saturation under long backpressure
        do_reset();
        out_ready = 1'b0; req = bit_of(1) | bit_of(2);
`ifdef ROUND_ROBIN_EN
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(1);
`else
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(2);
`endif
        for (int i = 0; i < 300; i++) tick();
        chk("sat_drop", int'(drop_cnt), 255);
        chk("sat_ovf",  int'(ovf), 1);
        req = '0;
        tick();
        chk("sat_hold", int'(drop_cnt), 255);
        chk("sat_ovf0", int'(ovf), 0);
        out_ready = 1'b1;
        drain("sat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
